// File: rtl/dac_max_pkg.sv
// ---------------------------------------------------------------------------
// dac_max_pkg
// Shared definitions for the sequential max-finder (max_search_seq):
//   - default frame geometry N_DEF / W_DEF / IW_DEF
//   - scan FSM state encoding scan_state_t
//   - clog2 helper used for index-width legality checks
// ---------------------------------------------------------------------------
package dac_max_pkg;

  localparam int N_DEF  = 18;
  localparam int W_DEF  = 7;
  localparam int IW_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/max_search_seq_if.sv
// ---------------------------------------------------------------------------
// max_search_seq_if
// Frame request / result bundle for max_search_seq.
//   start    : request to capture data_in and begin a scan
//   data_in  : flat frame, code k at [k*W+W-1 : k*W]
//   busy     : scan in progress (SCAN or DONE)
//   done     : one-cycle result strobe
//   max_out  : frame maximum, held until the next done
//   max_idx  : index of the maximum (only with MAX_INDEX_EN)
// Modports: master (frame producer), slave (max_search_seq).
// Configuration macro: MAX_INDEX_EN adds max_idx.
// ---------------------------------------------------------------------------
interface max_search_seq_if #(
  parameter int N  = 18,
  parameter int W  = 7,
  parameter int IW = 5
) ();

  logic           start;
  logic [N*W-1:0] data_in;
  logic           busy;
  logic           done;
  logic [W-1:0]   max_out;
`ifdef MAX_INDEX_EN
  logic [IW-1:0]  max_idx;
`endif

  // The index output must be able to name every code in the frame.
  if ((1 << IW) < N) begin : g_iw_too_small
    $error("max_search_seq_if: IW too small for N");
  end

`ifdef MAX_INDEX_EN
  modport master (output start, data_in, input busy, done, max_out, max_idx);
  modport slave  (input start, data_in, output busy, done, max_out, max_idx);
`else
  modport master (output start, data_in, input busy, done, max_out);
  modport slave  (input start, data_in, output busy, done, max_out);
`endif

endinterface

// File: rtl/max_cmp2.sv
// ---------------------------------------------------------------------------
// max_cmp2
// W-bit unsigned 2-input max.
//   in0_i, in1_i : operands
//   max_o        : larger operand (in1_i on a tie)
//   sel_o        : 1 when in1_i >= in0_i
// ---------------------------------------------------------------------------
module max_cmp2 #(
  parameter int W = 7
) (
  input  logic [W-1:0] in0_i,
  input  logic [W-1:0] in1_i,
  output logic [W-1:0] max_o,
  output logic         sel_o
);

  // >= makes ties resolve to in1, which the scan uses as "later index wins".
  assign sel_o = (in1_i >= in0_i);
  assign max_o = sel_o ? in1_i : in0_i;

endmodule

// File: rtl/max_search_seq.sv
// ---------------------------------------------------------------------------
// max_search_seq
// Sequential max-finder: captures a frame of N unsigned W-bit codes on an
// accepted start, then scans them with one shared comparator, one code per
// cycle. done pulses N cycles after start is accepted, with max_out (and
// max_idx) valid in that cycle.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset (aborts a scan, clears outputs)
//   bus : max_search_seq_if.slave (start, data_in, busy, done, max_out,
//         max_idx)
// Configuration macro: MAX_INDEX_EN builds the index tracking and max_idx.
// ---------------------------------------------------------------------------
module max_search_seq
  import dac_max_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int W  = W_DEF,
  parameter int IW = IW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  max_search_seq_if.slave bus
);

  if (N < 2 || N > 32 || clog2(N) > IW) begin : g_param_err
    $error("max_search_seq: illegal N/IW combination");
  end

  scan_state_t   state_q, state_d;
  logic [W-1:0]  frame_q [N];
  logic [W-1:0]  frame_d [N];
  logic [W-1:0]  acc_q, acc_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  max_out_q, max_out_d;
  logic [W-1:0]  cmp_in1;
  logic [W-1:0]  cmp_max;
`ifdef MAX_INDEX_EN
  logic          cmp_sel;
  logic [IW-1:0] acc_idx_q, acc_idx_d;
  logic [IW-1:0] max_idx_q, max_idx_d;
`else
  logic          cmp_sel_unused;
`endif

  assign cmp_in1 = frame_q[cnt_q];

  max_cmp2 #(.W(W)) u_cmp (
    .in0_i (acc_q),
    .in1_i (cmp_in1),
    .max_o (cmp_max),
`ifdef MAX_INDEX_EN
    .sel_o (cmp_sel)
`else
    .sel_o (cmp_sel_unused)
`endif
  );

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    max_out_d = max_out_q;
`ifdef MAX_INDEX_EN
    acc_idx_d = acc_idx_q;
    max_idx_d = max_idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          for (int k = 0; k < N; k++) begin
            frame_d[k] = bus.data_in[k*W +: W];
          end
          // Code 0 seeds the accumulator, so the scan starts at index 1.
          acc_d   = bus.data_in[W-1:0];
          cnt_d   = IW'(1);
`ifdef MAX_INDEX_EN
          acc_idx_d = '0;
`endif
          state_d = SCAN;
        end
      end
      SCAN: begin
        acc_d = cmp_max;
`ifdef MAX_INDEX_EN
        if (cmp_sel) acc_idx_d = cnt_q;
`endif
        if (cnt_q == IW'(N - 1)) begin
          // Load the results from the final compare so they are valid
          // during the single DONE cycle.
          max_out_d = cmp_max;
`ifdef MAX_INDEX_EN
          max_idx_d = cmp_sel ? cnt_q : acc_idx_q;
`endif
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      for (int k = 0; k < N; k++) frame_q[k] <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      max_out_q <= '0;
`ifdef MAX_INDEX_EN
      acc_idx_q <= '0;
      max_idx_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      max_out_q <= max_out_d;
`ifdef MAX_INDEX_EN
      acc_idx_q <= acc_idx_d;
      max_idx_q <= max_idx_d;
`endif
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.max_out = max_out_q;
`ifdef MAX_INDEX_EN
  assign bus.max_idx = max_idx_q;
`endif

endmodule

// File: tb/tb_max_search_seq.sv
// ---------------------------------------------------------------------------
// tb_max_search_seq
// Directed bench for max_search_seq with default geometry (N=18, W=7, IW=5).
// Each run drives start/rst/data_in per cycle from masks, logs the outputs
// of every cycle, and the expected values are then compared against the log.
// Cycle 0 of a run is the cycle in which the first start is presented.
// ---------------------------------------------------------------------------
module tb_max_search_seq;
  import dac_max_pkg::*;

  localparam int N  = N_DEF;
  localparam int W  = W_DEF;
  localparam int IW = IW_DEF;
  localparam int LOGN = 64;

  logic clk;
  logic rst;

  max_search_seq_if #(.N(N), .W(W), .IW(IW)) bus ();

  max_search_seq #(.N(N), .W(W), .IW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  logic         busy_log [LOGN];
  logic         done_log [LOGN];
  logic [W-1:0] max_log  [LOGN];
`ifdef MAX_INDEX_EN
  logic [IW-1:0] idx_log [LOGN];
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // fill < 0 gives code k = k; otherwise all codes = fill except ia/ib.
  function automatic logic [N*W-1:0] mk(input int fill, input int ia, input int va,
                                        input int ib, input int vb);
    logic [N*W-1:0] r;
    int v;
    r = '0;
    for (int k = 0; k < N; k++) begin
      v = (fill < 0) ? k : fill;
      if (k == ia) v = va;
      if (k == ib) v = vb;
      r[k*W +: W] = W'(v);
    end
    return r;
  endfunction

  task automatic run(input logic [N*W-1:0] f1, input logic [N*W-1:0] f2, input int chg,
                     input logic [63:0] smask, input logic [63:0] rmask, input int ncyc);
    for (int c = 0; c < LOGN; c++) begin
      busy_log[c] = 1'b0;
      done_log[c] = 1'b0;
      max_log[c]  = '0;
`ifdef MAX_INDEX_EN
      idx_log[c]  = '0;
`endif
    end
    for (int c = 0; c < ncyc; c++) begin
      bus.start   = smask[c];
      rst         = rmask[c];
      bus.data_in = (c >= chg) ? f2 : f1;
      @(negedge clk);
      busy_log[c] = bus.busy;
      done_log[c] = bus.done;
      max_log[c]  = bus.max_out;
`ifdef MAX_INDEX_EN
      idx_log[c]  = bus.max_idx;
`endif
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    rst       = 1'b0;
  endtask

  function automatic int first_done(input int ncyc);
    for (int c = 0; c < ncyc; c++) if (done_log[c]) return c;
    return -1;
  endfunction

  function automatic int done_count(input int ncyc);
    int n;
    n = 0;
    for (int c = 0; c < ncyc; c++) if (done_log[c]) n++;
    return n;
  endfunction

  function automatic int busy_count(input int lo, input int hi);
    int n;
    n = 0;
    for (int c = lo; c <= hi; c++) if (busy_log[c]) n++;
    return n;
  endfunction

  logic [N*W-1:0] f_asc, f_max0, f_tie, f_zero, f_full;

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.data_in = '0;
    f_asc  = mk(-1, -1, 0, -1, 0);
    f_max0 = mk(5, 0, 127, -1, 0);
    f_tie  = mk(10, 3, 90, 11, 90);
    f_zero = mk(0, -1, 0, -1, 0);
    f_full = mk(127, -1, 0, -1, 0);
    @(posedge clk);
    #1;

    // Reset state
    run(f_zero, f_zero, 1000, 64'h0, 64'h3, 3);
    chk("rst_busy", 32'(busy_log[2]), 32'd0);
    chk("rst_done", 32'(done_log[2]), 32'd0);
    chk("rst_max", 32'(max_log[2]), 32'd0);
`ifdef MAX_INDEX_EN
    chk("rst_idx", 32'(idx_log[2]), 32'd0);
`endif

    // Ascending frame
    run(f_asc, f_asc, 1000, 64'h1, 64'h0, 21);
    chk("asc_busy_c0", 32'(busy_log[0]), 32'd0);
    chk("asc_busy_1_18", 32'(busy_count(1, 18)), 32'd18);
    chk("asc_busy_c19", 32'(busy_log[19]), 32'd0);
    chk("asc_done_cyc", 32'(first_done(21)), 32'd18);
    chk("asc_done_cnt", 32'(done_count(21)), 32'd1);
    chk("asc_max", 32'(max_log[18]), 32'd17);
    chk("asc_max_hold", 32'(max_log[20]), 32'd17);
`ifdef MAX_INDEX_EN
    chk("asc_idx", 32'(idx_log[18]), 32'd17);
`endif

    // Maximum at index 0
    run(f_max0, f_max0, 1000, 64'h1, 64'h0, 20);
    chk("max0_done_cyc", 32'(first_done(20)), 32'd18);
    chk("max0_max", 32'(max_log[18]), 32'd127);
`ifdef MAX_INDEX_EN
    chk("max0_idx", 32'(idx_log[18]), 32'd0);
`endif

    // Tie: higher index wins
    run(f_tie, f_tie, 1000, 64'h1, 64'h0, 20);
    chk("tie_max", 32'(max_log[18]), 32'd90);
`ifdef MAX_INDEX_EN
    chk("tie_idx", 32'(idx_log[18]), 32'd11);
`endif

    // Reset mid-scan (cycle 9), new start in cycle 11
    run(f_max0, f_max0, 1000, (64'h1 | (64'h1 << 11)), (64'h1 << 9), 32);
    chk("rst_mid_max_before", 32'(max_log[9]), 32'd90);
    chk("rst_mid_max_after", 32'(max_log[10]), 32'd0);
    chk("rst_mid_busy_after", 32'(busy_log[10]), 32'd0);
    chk("rst_mid_done_cnt", 32'(done_count(32)), 32'd1);
    chk("rst_mid_done_cyc", 32'(first_done(32)), 32'd29);
    chk("rst_mid_max2", 32'(max_log[29]), 32'd127);
`ifdef MAX_INDEX_EN
    chk("rst_mid_idx_after", 32'(idx_log[10]), 32'd0);
    chk("rst_mid_idx2", 32'(idx_log[29]), 32'd0);
`endif

    // start pulsed while busy (cycles 4 and 18) is ignored
    run(f_tie, f_asc, 5, (64'h1 | (64'h1 << 4) | (64'h1 << 18)), 64'h0, 25);
    chk("busy_start_done_cnt", 32'(done_count(25)), 32'd1);
    chk("busy_start_done_cyc", 32'(first_done(25)), 32'd18);
    chk("busy_start_max", 32'(max_log[18]), 32'd90);

    // start held high: second frame accepted in cycle 19, done at 37
    run(f_asc, f_asc, 1000, ((64'h1 << 38) - 64'h1), 64'h0, 40);
    chk("held_done_cnt", 32'(done_count(40)), 32'd2);
    chk("held_done1", 32'(done_log[18]), 32'd1);
    chk("held_done2", 32'(done_log[37]), 32'd1);
    chk("held_busy_c19", 32'(busy_log[19]), 32'd0);
    chk("held_busy_c20", 32'(busy_log[20]), 32'd1);

    // data_in changes after capture have no effect
    run(f_zero, f_full, 2, 64'h1, 64'h0, 20);
    chk("stab_max_hold", 32'(max_log[17]), 32'd17);
    chk("stab_done_cyc", 32'(first_done(20)), 32'd18);
    chk("stab_max", 32'(max_log[18]), 32'd0);
`ifdef MAX_INDEX_EN
    chk("stab_idx", 32'(idx_log[18]), 32'd17);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
